// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N producers
module fifo_wr_arbiter #(
   parameter int N = 4,
   parameter int DWIDTH = 32,
   parameter int BURST_LEN = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid,
   input  logic [N-1:0]          req_last,
   input  logic [N*DWIDTH-1:0]   req_data,
   output logic [N-1:0]          req_ready,
   output logic [DWIDTH-1:0]     fifo_din,
   output logic                  fifo_wen,
   input  logic                  fifo_full,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
);
   localparam int CW = $clog2(BURST_LEN + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, owner_nxt;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [DWIDTH-1:0] data_a [N];
   logic found, xfer, rel;
   for (genvar i = 0; i < N; i++) begin : g_slice
      assign data_a[i] = req_data[i*DWIDTH +: DWIDTH];
   end
   assign xfer = state_q == BURST && req_valid[owner_q] && !fifo_full;
   assign rel = state_q == BURST && (!req_valid[owner_q] ||
                (xfer && (beat_cnt_q == CW'(BURST_LEN - 1) || req_last[owner_q])));
   assign owner_nxt = owner_q == IDW'(N - 1) ? '0 : owner_q + 1'b1;
   // round-robin scan starting at rr_ptr, wrapping explicitly at N
   always_comb begin
      logic [IDW:0] sum;
      logic [IDW:0] ix;
      found = 1'b0;
      win = '0;
      sum = '0;
      ix = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         ix = sum >= (IDW+1)'(N) ? sum - (IDW+1)'(N) : sum;
         if (!found && req_valid[ix[IDW-1:0]]) begin
            found = 1'b1;
            win = ix[IDW-1:0];
         end
      end
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_ptr_q <= '0;
         owner_q <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
   // next state: grant in IDLE, count beats and release in BURST
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d = owner_q;
      beat_cnt_d = beat_cnt_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = BURST;
            owner_d = win;
            beat_cnt_d = '0;
         end
      end else begin
         beat_cnt_d = xfer ? beat_cnt_q + 1'b1 : beat_cnt_q;
         if (rel) begin
            state_d = IDLE;
            rr_ptr_d = owner_nxt;
         end
      end
   end
   // outputs: write path is combinational and suppressed while rst is high
   always_comb begin
      req_ready = (xfer && !rst) ? N'(1) << owner_q : '0;
      fifo_wen = xfer && !rst;
      fifo_din = (state_q == BURST && !rst) ? data_a[owner_q] : '0;
      busy = state_q == BURST && !rst;
      grant_id = owner_q;
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tests for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int DW = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N*DW-1:0] req_data = '0;
   logic [DW-1:0] fifo_din;
   logic fifo_wen, busy;
   logic fifo_full = 1'b0;
   logic [1:0] grant_id;
   logic [2:0] v3 = '0, l3 = '0, rdy3;
   logic [3*DW-1:0] d3 = '0;
   logic [DW-1:0] din3;
   logic wen3, busy3;
   logic full3 = 1'b0;
   logic [1:0] gid3;
   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .DWIDTH(DW), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .fifo_din(fifo_din),
      .fifo_wen(fifo_wen), .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
   );

   fifo_wr_arbiter #(.N(3), .DWIDTH(DW), .BURST_LEN(4)) dut3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_last(l3),
      .req_data(d3), .req_ready(rdy3), .fifo_din(din3),
      .fifo_wen(wen3), .fifo_full(full3), .grant_id(gid3), .busy(busy3)
   );

   task automatic do_reset;
      rst = 1'b1;
      req_valid = '0;
      req_last = '0;
      fifo_full = 1'b0;
      v3 = '0;
      l3 = '0;
      full3 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = '1;
      v3 = '1;
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         compared++;
         if ({fifo_wen, req_ready, busy, grant_id} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy, grant_id}, 8'b0);
         end
         compared++;
         if ({wen3, rdy3, busy3, gid3} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_out3 c%0d got %b want %b", c, {wen3, rdy3, busy3, gid3}, 7'b0);
         end
         @(posedge clk);
      end
   endtask

   task automatic test_single;
      int n = 0;
      logic ew;
      logic [3:0] er;
      do_reset();
      req_valid = 4'b0010;
      req_data[DW +: DW] = 32'h10;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ew = (c % 5) != 0;
         er = ew ? 4'b0010 : 4'b0000;
         compared++;
         if ({fifo_wen, req_ready, busy} !== {ew, er, ew}) begin
            mismatched++;
            $display("FAIL single_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy}, {ew, er, ew});
         end
         if (ew) begin
            compared++;
            if (fifo_din !== 32'h10 + n) begin
               mismatched++;
               $display("FAIL single_din c%0d got %h want %h", c, fifo_din, 32'h10 + n);
            end
            n++;
         end
         @(posedge clk);
         #1 req_data[DW +: DW] = 32'h10 + n;
      end
   endtask

   task automatic test_all;
      int cnt [4] = '{0, 0, 0, 0};
      int g;
      logic ew;
      logic [3:0] er;
      logic [1:0] eg;
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = i * 256;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         g = (c / 5) % 4;
         ew = (c % 5) != 0;
         er = ew ? 4'(1 << g) : 4'b0000;
         eg = ew ? 2'(g) : (c == 0 ? 2'd0 : 2'(((c / 5) + 3) % 4));
         compared++;
         if ({fifo_wen, req_ready, busy, grant_id} !== {ew, er, ew, eg}) begin
            mismatched++;
            $display("FAIL all_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy, grant_id}, {ew, er, ew, eg});
         end
         if (ew) begin
            compared++;
            if (fifo_din !== 32'(g * 256 + cnt[g])) begin
               mismatched++;
               $display("FAIL all_din c%0d got %h want %h", c, fifo_din, 32'(g * 256 + cnt[g]));
            end
            cnt[g]++;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = i * 256 + cnt[i];
      end
   endtask

   task automatic test_full;
      int n = 0;
      logic ew, eb;
      logic [3:0] er;
      do_reset();
      req_valid = 4'b0001;
      req_data[0 +: DW] = 32'hA0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         ew = c == 1 || c == 2 || c == 6 || c == 7;
         eb = c >= 1;
         er = ew ? 4'b0001 : 4'b0000;
         compared++;
         if ({fifo_wen, req_ready, busy} !== {ew, er, eb}) begin
            mismatched++;
            $display("FAIL full_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy}, {ew, er, eb});
         end
         if (ew) begin
            compared++;
            if (fifo_din !== 32'hA0 + n) begin
               mismatched++;
               $display("FAIL full_din c%0d got %h want %h", c, fifo_din, 32'hA0 + n);
            end
            n++;
         end
         @(posedge clk);
         #1;
         req_data[0 +: DW] = 32'hA0 + n;
         fifo_full = c + 1 >= 3 && c + 1 <= 5;
      end
   endtask

   task automatic test_last;
      logic [3:0] er [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
      logic eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0] eg [5] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
      logic [31:0] ed [5] = '{32'h0, 32'h200, 32'h201, 32'h0, 32'h300};
      do_reset();
      req_valid = 4'b1100;
      req_data[2*DW +: DW] = 32'h200;
      req_data[3*DW +: DW] = 32'h300;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         compared++;
         if ({fifo_wen, req_ready, busy, grant_id} !== {er[c] != 0, er[c], eb[c], eg[c]}) begin
            mismatched++;
            $display("FAIL last_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy, grant_id}, {er[c] != 0, er[c], eb[c], eg[c]});
         end
         if (er[c] != 0) begin
            compared++;
            if (fifo_din !== ed[c]) begin
               mismatched++;
               $display("FAIL last_din c%0d got %h want %h", c, fifo_din, ed[c]);
            end
         end
         @(posedge clk);
         #1;
         if (c == 1) begin
            req_data[2*DW +: DW] = 32'h201;
            req_last = 4'b0100;
         end
         if (c == 2) begin
            req_last = 4'b0000;
            req_valid = 4'b1000;
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0] er [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
      logic eb [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] eg [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      logic [31:0] ed [6] = '{32'h0, 32'h100, 32'h100, 32'h0, 32'h0, 32'hAA};
      do_reset();
      req_valid = 4'b0010;
      req_data[0 +: DW] = 32'hAA;
      req_data[DW +: DW] = 32'h100;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         compared++;
         if ({fifo_wen, req_ready, busy, grant_id} !== {er[c] != 0, er[c], eb[c], eg[c]}) begin
            mismatched++;
            $display("FAIL rstmid_out c%0d got %b want %b", c, {fifo_wen, req_ready, busy, grant_id}, {er[c] != 0, er[c], eb[c], eg[c]});
         end
         if (er[c] != 0) begin
            compared++;
            if (fifo_din !== ed[c]) begin
               mismatched++;
               $display("FAIL rstmid_din c%0d got %h want %h", c, fifo_din, ed[c]);
            end
         end
         @(posedge clk);
         #1;
         if (c == 2) begin
            rst = 1'b1;
            req_valid = 4'b0011;
         end
         if (c == 3) rst = 1'b0;
      end
   endtask

   task automatic test_wrap;
      logic [2:0] er [7] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
      logic eb [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0] eg [7] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      logic [31:0] ed [7] = '{32'h0, 32'h32, 32'h32, 32'h32, 32'h32, 32'h0, 32'h30};
      do_reset();
      v3 = 3'b100;
      d3 = {32'h32, 32'h31, 32'h30};
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         compared++;
         if ({wen3, rdy3, busy3, gid3} !== {er[c] != 0, er[c], eb[c], eg[c]}) begin
            mismatched++;
            $display("FAIL wrap_out c%0d got %b want %b", c, {wen3, rdy3, busy3, gid3}, {er[c] != 0, er[c], eb[c], eg[c]});
         end
         if (er[c] != 0) begin
            compared++;
            if (din3 !== ed[c]) begin
               mismatched++;
               $display("FAIL wrap_din c%0d got %h want %h", c, din3, ed[c]);
            end
         end
         @(posedge clk);
         #1;
         if (c == 0) v3 = 3'b111;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all();
      test_full();
      test_last();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
